// File: rtl/cc_level_pkg.sv
// Shared types and the default Frogger level table for the level sequencer.
package cc_level_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} lvlState_t;

  localparam int TBL_LEVELS = 3;
  localparam int TBL_ROWS   = 13;
  localparam int TBL_DW     = 8;

  typedef logic [TBL_DW-1:0] tblWord_t;

  // One word per screen row, bottom row first.
  localparam tblWord_t LEVEL_TABLE [TBL_LEVELS][TBL_ROWS] = '{
    '{8'h10, 8'h90, 8'h40, 8'hC0, 8'hD0, 8'h20, 8'hA0, 8'h30, 8'hB0, 8'h50, 8'h60, 8'h70, 8'h80},
    '{8'hD0, 8'hD0, 8'h60, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA},
    '{8'h50, 8'h90, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B}
  };

endpackage

// File: rtl/cc_level_rom.sv
// Combinational {level,row} -> row word lookup; out-of-range addresses read as zero.
module cc_level_rom
  import cc_level_pkg::*;
#(
  parameter int DATAWIDTH      = 8,
  parameter int NUM_LEVELS     = 3,
  parameter int ROWS_PER_LEVEL = 13,
  parameter int LEVEL_W        = 2,
  parameter int ROW_W          = 4
) (
  input  logic [LEVEL_W-1:0]   level,
  input  logic [ROW_W-1:0]     row,
  output logic [DATAWIDTH-1:0] data
);

  always_comb begin
    data = '0;
    if (32'(level) < NUM_LEVELS && 32'(row) < ROWS_PER_LEVEL &&
        32'(level) < TBL_LEVELS && 32'(row) < TBL_ROWS)
      data = DATAWIDTH'(LEVEL_TABLE[level][row]);
  end

endmodule

// File: rtl/cc_level_sequencer.sv
// Streams one level-table row per Tick and tracks level progress/advance/wrap.
// Optional CC_LEVEL_SEQUENCER_LOOP_EN: rows repeat in RUN, LevelDone pulses, DONE unused.
module cc_level_sequencer
  import cc_level_pkg::*;
#(
  parameter int DATAWIDTH      = 8,
  parameter int NUM_LEVELS     = 3,
  parameter int ROWS_PER_LEVEL = 13,
  localparam int LEVEL_W       = $clog2(NUM_LEVELS),
  localparam int ROW_W         = $clog2(ROWS_PER_LEVEL + 1)
) (
  input  logic                 CC_LEVEL_SEQUENCER_CLOCK_50,
  input  logic                 CC_LEVEL_SEQUENCER_RESET_InHigh,
  input  logic                 CC_LEVEL_SEQUENCER_Start_In,
  input  logic [LEVEL_W-1:0]   CC_LEVEL_SEQUENCER_LevelSel_InBus,
  input  logic                 CC_LEVEL_SEQUENCER_Tick_In,
  input  logic                 CC_LEVEL_SEQUENCER_NextLevel_In,
  input  logic                 CC_LEVEL_SEQUENCER_Abort_In,
  output logic [DATAWIDTH-1:0] CC_LEVEL_SEQUENCER_LevelData_OutBus,
  output logic                 CC_LEVEL_SEQUENCER_DataValid_Out,
  output logic [ROW_W-1:0]     CC_LEVEL_SEQUENCER_Progress_OutBus,
  output logic [LEVEL_W-1:0]   CC_LEVEL_SEQUENCER_CurrentLvl_OutBus,
  output logic                 CC_LEVEL_SEQUENCER_LevelDone_Out,
  output logic                 CC_LEVEL_SEQUENCER_Busy_Out,
  output logic                 CC_LEVEL_SEQUENCER_Wrap_Out
);

  lvlState_t             state, stateNext;
  logic [LEVEL_W-1:0]    level, levelNext;
  logic [ROW_W-1:0]      progress, progressNext, progressInc;
  logic [DATAWIDTH-1:0]  rowData, dataP1, dataNext;
  logic                  vldP1, vldNext;
  logic                  wrapP1, wrapNext;
  logic                  lastRow, lastLevel;
`ifdef CC_LEVEL_SEQUENCER_LOOP_EN
  logic                  donePulse, donePulseNext;
`endif

  cc_level_rom #(
    .DATAWIDTH      (DATAWIDTH),
    .NUM_LEVELS     (NUM_LEVELS),
    .ROWS_PER_LEVEL (ROWS_PER_LEVEL),
    .LEVEL_W        (LEVEL_W),
    .ROW_W          (ROW_W)
  ) uRom (
    .level (level),
    .row   (progress),
    .data  (rowData)
  );

  assign progressInc = progress + ROW_W'(1);
  assign lastRow     = (progressInc == ROW_W'(ROWS_PER_LEVEL));
  assign lastLevel   = (level == LEVEL_W'(NUM_LEVELS - 1));

  always_comb begin
    stateNext    = state;
    levelNext    = level;
    progressNext = progress;
    dataNext     = dataP1;
    vldNext      = 1'b0;
    wrapNext     = 1'b0;
`ifdef CC_LEVEL_SEQUENCER_LOOP_EN
    donePulseNext = 1'b0;
`endif
    if (CC_LEVEL_SEQUENCER_Abort_In) begin
      stateNext    = IDLE;
      levelNext    = '0;
      progressNext = '0;
      dataNext     = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (CC_LEVEL_SEQUENCER_Start_In) begin
            stateNext    = RUN;
            levelNext    = (32'(CC_LEVEL_SEQUENCER_LevelSel_InBus) >= NUM_LEVELS)
                           ? '0 : CC_LEVEL_SEQUENCER_LevelSel_InBus;
            progressNext = '0;
          end
        end
        RUN: begin
`ifdef CC_LEVEL_SEQUENCER_LOOP_EN
          if (CC_LEVEL_SEQUENCER_NextLevel_In) begin
            progressNext = '0;
            levelNext    = lastLevel ? '0 : level + LEVEL_W'(1);
            wrapNext     = lastLevel;
          end else if (CC_LEVEL_SEQUENCER_Tick_In) begin
            dataNext      = rowData;
            vldNext       = 1'b1;
            progressNext  = lastRow ? '0 : progressInc;
            donePulseNext = lastRow;
          end
`else
          if (CC_LEVEL_SEQUENCER_Tick_In) begin
            dataNext     = rowData;
            vldNext      = 1'b1;
            progressNext = progressInc;
            if (lastRow)
              stateNext = DONE;
          end
`endif
        end
        DONE: begin
          // NextLevel wins over a coincident Tick; the Tick is simply dropped.
          if (CC_LEVEL_SEQUENCER_NextLevel_In) begin
            stateNext    = RUN;
            progressNext = '0;
            levelNext    = lastLevel ? '0 : level + LEVEL_W'(1);
            wrapNext     = lastLevel;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // Registered outputs: one cycle after the sampled Tick/Start/NextLevel.
  always_ff @(posedge CC_LEVEL_SEQUENCER_CLOCK_50) begin
    if (CC_LEVEL_SEQUENCER_RESET_InHigh) begin
      state     <= IDLE;
      level     <= '0;
      progress  <= '0;
      dataP1    <= '0;
      vldP1     <= 1'b0;
      wrapP1    <= 1'b0;
`ifdef CC_LEVEL_SEQUENCER_LOOP_EN
      donePulse <= 1'b0;
`endif
    end else begin
      state     <= stateNext;
      level     <= levelNext;
      progress  <= progressNext;
      dataP1    <= dataNext;
      vldP1     <= vldNext;
      wrapP1    <= wrapNext;
`ifdef CC_LEVEL_SEQUENCER_LOOP_EN
      donePulse <= donePulseNext;
`endif
    end
  end

  assign CC_LEVEL_SEQUENCER_LevelData_OutBus  = dataP1;
  assign CC_LEVEL_SEQUENCER_DataValid_Out     = vldP1;
  assign CC_LEVEL_SEQUENCER_Progress_OutBus   = progress;
  assign CC_LEVEL_SEQUENCER_CurrentLvl_OutBus = level;
  assign CC_LEVEL_SEQUENCER_Busy_Out          = (state == RUN);
  assign CC_LEVEL_SEQUENCER_Wrap_Out          = wrapP1;
`ifdef CC_LEVEL_SEQUENCER_LOOP_EN
  assign CC_LEVEL_SEQUENCER_LevelDone_Out     = donePulse;
`else
  assign CC_LEVEL_SEQUENCER_LevelDone_Out     = (state == DONE);
`endif

endmodule

// File: tb/tb_cc_level_sequencer.sv
// Directed bench for cc_level_sequencer: behavioural model checked every cycle plus literal spot checks.
module tb_cc_level_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, tick, nextLvl, abort;
  logic [1:0] sel;
  logic [7:0] dData;
  logic       dValid, dDone, dBusy, dWrap;
  logic [3:0] dProg;
  logic [1:0] dLvl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cc_level_sequencer dut (
    .CC_LEVEL_SEQUENCER_CLOCK_50         (clk),
    .CC_LEVEL_SEQUENCER_RESET_InHigh     (rst),
    .CC_LEVEL_SEQUENCER_Start_In         (start),
    .CC_LEVEL_SEQUENCER_LevelSel_InBus   (sel),
    .CC_LEVEL_SEQUENCER_Tick_In          (tick),
    .CC_LEVEL_SEQUENCER_NextLevel_In     (nextLvl),
    .CC_LEVEL_SEQUENCER_Abort_In         (abort),
    .CC_LEVEL_SEQUENCER_LevelData_OutBus (dData),
    .CC_LEVEL_SEQUENCER_DataValid_Out    (dValid),
    .CC_LEVEL_SEQUENCER_Progress_OutBus  (dProg),
    .CC_LEVEL_SEQUENCER_CurrentLvl_OutBus(dLvl),
    .CC_LEVEL_SEQUENCER_LevelDone_Out    (dDone),
    .CC_LEVEL_SEQUENCER_Busy_Out         (dBusy),
    .CC_LEVEL_SEQUENCER_Wrap_Out         (dWrap)
  );

  // Bench's own copy of the level table.
  int tbl [3][13] = '{
    '{'h10, 'h90, 'h40, 'hC0, 'hD0, 'h20, 'hA0, 'h30, 'hB0, 'h50, 'h60, 'h70, 'h80},
    '{'hD0, 'hD0, 'h60, 'h11, 'h22, 'h33, 'h44, 'h55, 'h66, 'h77, 'h88, 'h99, 'hAA},
    '{'h50, 'h90, 'h01, 'h02, 'h03, 'h04, 'h05, 'h06, 'h07, 'h08, 'h09, 'h0A, 'h0B}
  };

`ifdef CC_LEVEL_SEQUENCER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  // Model: mode 0=idle, 1=running, 2=finished level.
  int  mMode = 0, mLvl = 0, mProg = 0, mData = 0;
  bit  mValid = 0, mWrap = 0, mPulse = 0;
  bit  armed = 0;

  task automatic modelAdvance();
    mProg = 0;
    mMode = 1;
    if (mLvl == 2) begin
      mLvl  = 0;
      mWrap = 1;
    end else begin
      mLvl = mLvl + 1;
    end
  endtask

  always @(posedge clk) begin
    armed = 1;
    mValid = 0;
    mWrap  = 0;
    mPulse = 0;
    if (rst) begin
      mMode = 0; mLvl = 0; mProg = 0; mData = 0;
    end else if (abort) begin
      mMode = 0; mLvl = 0; mProg = 0; mData = 0;
    end else if (mMode == 0) begin
      if (start) begin
        mMode = 1;
        mProg = 0;
        mLvl  = (int'(sel) < 3) ? int'(sel) : 0;
      end
    end else if (mMode == 1) begin
      if (LOOP && nextLvl) begin
        modelAdvance();
      end else if (tick) begin
        mData  = tbl[mLvl][mProg];
        mValid = 1;
        mProg  = mProg + 1;
        if (mProg == 13) begin
          if (LOOP) begin
            mProg  = 0;
            mPulse = 1;
          end else begin
            mMode = 2;
          end
        end
      end
    end else if (nextLvl) begin
      modelAdvance();
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("data",  32'(dData),  32'(mData));
      chk("valid", 32'(dValid), 32'(mValid));
      chk("prog",  32'(dProg),  32'(mProg));
      chk("level", 32'(dLvl),   32'(mLvl));
      chk("done",  32'(dDone),  LOOP ? 32'(mPulse) : 32'(mMode == 2));
      chk("busy",  32'(dBusy),  32'(mMode == 1));
      chk("wrap",  32'(dWrap),  32'(mWrap));
    end
  end

  task automatic drive(input bit s, input int l, input bit t, input bit n, input bit a);
    start = s; sel = 2'(l); tick = t; nextLvl = n; abort = a;
    @(negedge clk);
    start = 0; sel = 0; tick = 0; nextLvl = 0; abort = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1, 0, 0);
  endtask

  initial begin
    rst = 1; start = 0; sel = 0; tick = 0; nextLvl = 0; abort = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst_data", 32'(dData), 32'h0);
    chk("rst_busy", 32'(dBusy), 32'h0);
    chk("rst_lvl",  32'(dLvl),  32'h0);
    chk("rst_prog", 32'(dProg), 32'h0);

    // Level 0 from the start, 13 rows.
    drive(1, 0, 0, 0, 0);
    chk("start_busy", 32'(dBusy), 32'h1);
    for (int i = 0; i < 13; i++) begin
      drive(0, 0, 1, 0, 0);
      if (i == 0) begin chk("w0", 32'(dData), 32'h10); chk("w0_vld", 32'(dValid), 32'h1); end
      if (i == 1) chk("w1", 32'(dData), 32'h90);
      if (i == 2) chk("w2", 32'(dData), 32'h40);
      if (i == 3) chk("w3", 32'(dData), 32'hC0);
    end
    chk("end_done", 32'(dDone), 32'h1);
    if (LOOP) begin
      chk("end_prog", 32'(dProg), 32'h0);
      drive(0, 0, 1, 0, 0);
      chk("w14", 32'(dData), 32'h10);
      chk("w14_done", 32'(dDone), 32'h0);
    end else begin
      chk("end_prog", 32'(dProg), 32'd13);
      chk("end_busy", 32'(dBusy), 32'h0);
      drive(0, 0, 1, 0, 0);
      chk("done_tick_vld", 32'(dValid), 32'h0);
      chk("done_hold", 32'(dData), 32'h80);
    end

    // Tick and NextLevel together, then Start while running.
    drive(0, 0, 1, 1, 0);
    chk("tn_lvl", 32'(dLvl), 32'h1);
    chk("tn_vld", 32'(dValid), 32'h0);
    drive(1, 2, 0, 0, 0);
    chk("run_start_lvl", 32'(dLvl), 32'h1);

    // Level 1, level 2, then wrap to level 0.
    drive(0, 0, 1, 0, 0);
    chk("l1w0", 32'(dData), 32'hD0);
    ticks(12);
    drive(0, 0, 0, 1, 0);
    chk("l2_lvl", 32'(dLvl), 32'h2);
    drive(0, 0, 1, 0, 0);
    chk("l2w0", 32'(dData), 32'h50);
    ticks(12);
    drive(0, 0, 0, 1, 0);
    chk("wrap_lvl",  32'(dLvl),  32'h0);
    chk("wrap_puls", 32'(dWrap), 32'h1);
    chk("wrap_prog", 32'(dProg), 32'h0);
    chk("wrap_busy", 32'(dBusy), 32'h1);
    drive(0, 0, 0, 0, 0);
    chk("wrap_once", 32'(dWrap), 32'h0);
    drive(0, 0, 1, 0, 0);
    chk("wrap_w0", 32'(dData), 32'h10);

    // Abort at progress 5.
    ticks(4);
    chk("pre_abort_prog", 32'(dProg), 32'd5);
    drive(0, 0, 0, 0, 1);
    chk("ab_data", 32'(dData), 32'h0);
    chk("ab_prog", 32'(dProg), 32'h0);
    chk("ab_busy", 32'(dBusy), 32'h0);
    drive(0, 0, 1, 0, 0);
    chk("ab_tick_vld", 32'(dValid), 32'h0);

    // Out-of-range level select falls back to level 0.
    drive(1, 3, 0, 0, 0);
    chk("oor_lvl", 32'(dLvl), 32'h0);
    drive(0, 0, 1, 0, 0);
    chk("oor_w0", 32'(dData), 32'h10);

    // NextLevel ignored in idle.
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 1, 1, 0);
    chk("idle_nl_lvl",  32'(dLvl),  32'h0);
    chk("idle_nl_busy", 32'(dBusy), 32'h0);
    drive(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
